// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// Holds the FSM state enum, default parameters and the id width helper.
package fifo_arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 15;

  // Idle-beat counter width; holds any TIMEOUT up to 255.
  localparam int CNT_W = 8;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requesting index above last wins,
// wrapping to the lowest requesting index. Ports: req, last -> win, any.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N = DEF_NUM_REQ,
  localparam int W = id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] win,
  output logic         any
);

  logic [W-1:0] hi_win;
  logic [W-1:0] lo_win;
  logic         hi_any;

  // Descending scan so the lowest qualifying index is assigned last.
  always_comb begin
    hi_win = '0;
    lo_win = '0;
    hi_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_win = W'(i);
      end
      if (req[i] && (W'(i) > last)) begin
        hi_win = W'(i);
        hi_any = 1'b1;
      end
    end
  end

  assign any = |req;
  assign win = hi_any ? hi_win : lo_win;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter feeding one downstream sync FIFO write port.
// Ports: req_valid/last/data/mask in, req_ready out; fifo_full in,
// fifo_w_en/fifo_data out; grant_id, busy, timeout_pulse status.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int TIMEOUT    = DEF_TIMEOUT,
  localparam int IW         = id_w(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_mask,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          timeout_pulse
);

  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [IW-1:0]    LW_RST = IW'(NUM_REQ - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    gid_q;
  logic [IW-1:0]    gid_d;
  logic [IW-1:0]    lw_q;
  logic [IW-1:0]    lw_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tp_q;
  logic             tp_d;

  logic [NUM_REQ-1:0] cand;
  logic [IW-1:0]      win;
  logic               any;
  logic               in_grant;
  logic               g_valid;
  logic               g_last;
  logic               accept;

  assign cand = req_valid & req_mask;

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req  (cand),
    .last (lw_q),
    .win  (win),
    .any  (any)
  );

  assign in_grant = (state_q == S_GRANT);
  assign g_valid  = req_valid[gid_q];
  assign g_last   = req_last[gid_q];
  assign accept   = in_grant & g_valid & ~fifo_full;

  always_comb begin
    req_ready = '0;
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_grant && (gid_q == IW'(i))) begin
        req_ready[i] = accept;
        fifo_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_w_en     = accept;
  assign grant_id      = gid_q;
  assign busy          = in_grant;
  assign timeout_pulse = tp_q;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    lw_d    = lw_q;
    cnt_d   = cnt_q;
    tp_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          gid_d   = win;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (accept) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = S_IDLE;
            lw_d    = gid_q;
          end
        end else if (!g_valid && !fifo_full) begin
          // Only a silent requester ages the packet; a full FIFO does not.
          if (cnt_q == TMO_M1) begin
            tp_d    = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
            lw_d    = gid_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      gid_q   <= '0;
      lw_q    <= LW_RST;
      cnt_q   <= '0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      lw_q    <= lw_d;
      cnt_q   <= cnt_d;
      tp_q    <= tp_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameters NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, payload width.
REQ-003 SHALL have parameter TIMEOUT, default 15, idle-beat limit inside a packet (1..255).
REQ-004 SHALL have port i_clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester beat valid.
REQ-007 SHALL have port req_last, input, NUM_REQ: per-requester final beat of packet.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: requester i payload in slice i.
REQ-009 SHALL have port req_ready, output, NUM_REQ: per-requester beat accepted.
REQ-010 SHALL have port req_mask, input, NUM_REQ: 1 = requester eligible for arbitration.
REQ-011 SHALL have port fifo_full, input, 1: full flag from downstream sync FIFO.
REQ-012 SHALL have port fifo_w_en, output, 1: write enable to downstream FIFO.
REQ-013 SHALL have port fifo_data, output, DATA_WIDTH: write data to downstream FIFO.
REQ-014 SHALL have port grant_id, output, clog2(NUM_REQ): current/last granted requester.
REQ-015 SHALL have port busy, output, 1: high while state is GRANT.
REQ-016 SHALL have port timeout_pulse, output, 1: one-cycle pulse on packet abort.

Function
REQ-017 SHALL implement states IDLE and GRANT.
REQ-018 IDLE: if any req_valid & req_mask, SHALL register round-robin winner into grant_id and enter GRANT next cycle; else stay IDLE.
REQ-019 Round-robin SHALL search from (last_winner+1) mod NUM_REQ upward with wrap-around; lowest index after last winner wins.
REQ-020 GRANT: req_ready[grant_id] = fifo_w_en = req_valid[grant_id] & !fifo_full; all other req_ready bits SHALL be 0 (combinational from registered state).
REQ-021 fifo_data SHALL equal req_data slice grant_id in GRANT, 0 in IDLE.
REQ-022 Beat transfers when req_valid & req_ready; beat with req_last=1 SHALL return to IDLE and set last_winner = grant_id.
REQ-023 Arbitration latency: one IDLE cycle between packets; minimum packet cost = 1 + beats cycles.
REQ-024 fifo_full high SHALL stall without data loss and SHALL NOT advance the timeout counter.
REQ-025 Timeout counter SHALL increment each GRANT cycle with req_valid[grant_id]=0, clear on any accepted beat and on entering GRANT.
REQ-026 Counter reaching TIMEOUT SHALL pulse timeout_pulse, return to IDLE, set last_winner = grant_id.
REQ-027 req_mask changes mid-packet SHALL NOT affect the current grant; only arbitration in IDLE.
REQ-028 In IDLE req_ready and fifo_w_en SHALL be 0.

Reset
REQ-029 On i_rst_n=0 at a clock edge: state=IDLE, grant_id=0, last_winner=NUM_REQ-1, timeout counter=0, timeout_pulse=0.
REQ-030 Reset mid-packet SHALL abort the packet without timeout_pulse; requester 0 has first priority afterwards.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum, default NUM_REQ/DATA_WIDTH/TIMEOUT, and ID width function.
REQ-032 Sub-module rr_pick (combinational: request vector, last winner -> winner index, any flag) SHALL perform the round-robin search.

Verification
REQ-033 Req0,1,2 each send 2-beat packet simultaneously after reset -> FIFO receives order 0,0,1,1,2,2; grant_id 0,1,2.
REQ-034 Req3 wins, then all four request -> next grants 0,1,2,3 (wrap-around).
REQ-035 fifo_full held high 5 cycles mid-packet -> no writes, no timeout_pulse, packet completes intact after release.
REQ-036 Granted requester drops valid 15 cycles, TIMEOUT=15 -> timeout_pulse one cycle, IDLE, next requester granted.
REQ-037 req_mask=4'b1101 with all valid -> requester 1 never granted; clearing mask bit mid-packet of req2 does not cut it.
REQ-038 Reset asserted in GRANT mid-packet -> next cycle busy=0, req_ready=0, fifo_w_en=0; then req0 wins first.
